// File: rtl/joy_db15_responder.sv
// Device-side DB15 joystick adapter model: two cascaded 16-bit PISO registers clocked by the reader's joy_clk/joy_load.
// Latency: joy_clk pin edge to joy_data change is at most SYNC_STAGES+2 clk cycles; frame_done and bit_cnt=32 update together.
// No backpressure: the reader fully paces the link; shift edges arriving while load is held are counted in edge_err and dropped.
module joy_db15_responder #(
  parameter int SYNC_STAGES = 2,        // minimum 2
  parameter int TIMEOUT     = 2**20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] p1,
  input  logic [15:0] p2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic        frame_done,
  output logic [5:0]  bit_cnt,
  output logic        link_active,
  output logic [7:0]  edge_err
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic                   clk_prev_q, load_prev_q;
  logic [31:0]            shreg_q, shreg_d;
  logic                   joy_data_q, joy_data_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   link_active_q, link_active_d;
  logic [7:0]             edge_err_q, edge_err_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic        clk_s, load_s, clk_rise, load_fall;
  logic [31:0] img;

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign load_fall = ~load_s & load_prev_q;
  // Buttons are active-low on the wire; p1[15] leaves first.
  assign img       = ~{p1, p2};

  // Synchronizer chains shift the asynchronous pins in at the LSB.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
    load_sync_d = {load_sync_q[SYNC_STAGES-2:0], joy_load};
  end

  // Frame FSM: a held load reloads the image every cycle (74HC165 style); shift edges are ignored while loading.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    edge_err_d   = edge_err_q;
    joy_data_d   = shreg_q[31];
    if (clk_rise && !load_s && edge_err_q != 8'hFF)
      edge_err_d = edge_err_q + 8'd1;
    if (!load_s) begin
      // Covers a mid-frame abort too: no frame_done, count restarts.
      state_d   = LOAD;
      shreg_d   = img;
      bit_cnt_d = 6'd0;
    end else begin
      if (state_q == LOAD)
        state_d = SHIFT;
      if (clk_rise) begin
        shreg_d = {shreg_q[30:0], 1'b1};
        if (bit_cnt_q != 6'd32)
          bit_cnt_d = bit_cnt_q + 6'd1;
        // Only a frame in flight completes; idle shifting past 32 stays silent.
        if (state_q != IDLE && bit_cnt_q == 6'd31) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
    end
  end

  // Link watchdog: every load falling edge restarts it; it saturates at TIMEOUT and drops link_active there.
  always_comb begin
    link_active_d = link_active_q;
    wd_d          = wd_q;
    if (load_fall) begin
      link_active_d = 1'b1;
      wd_d          = '0;
    end else begin
      if (wd_q != WD_MAX)
        wd_d = wd_q + WD_W'(1);
      if (wd_d == WD_MAX)
        link_active_d = 1'b0;
    end
  end

  // All state registers; reset forces joy_data high asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q    <= '0;
      load_sync_q   <= '1;
      clk_prev_q    <= 1'b0;
      load_prev_q   <= 1'b1;
      state_q       <= IDLE;
      shreg_q       <= 32'hFFFF_FFFF;
      joy_data_q    <= 1'b1;
      bit_cnt_q     <= 6'd0;
      frame_done_q  <= 1'b0;
      edge_err_q    <= 8'd0;
      link_active_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      load_sync_q   <= load_sync_d;
      clk_prev_q    <= clk_s;
      load_prev_q   <= load_s;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      joy_data_q    <= joy_data_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_done_q  <= frame_done_d;
      edge_err_q    <= edge_err_d;
      link_active_q <= link_active_d;
      wd_q          <= wd_d;
    end
  end

  assign joy_data    = joy_data_q;
  assign frame_done  = frame_done_q;
  assign bit_cnt     = bit_cnt_q;
  assign link_active = link_active_q;
  assign edge_err    = edge_err_q;

endmodule
